// File: rtl/scene_sequencer.sv
// Frame-synchronous offset animator: a vsync-derived frame tick drives a
// COUNT -> ANIM -> HOLD sequence, free-running wrap channels and a lane offset.
module scene_sequencer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned OFF_W     = 12,
    parameter int unsigned COUNTDOWN = 5,
    parameter int unsigned LANE_STEP = 100
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic                    vsync_in,
    input  logic                    restart,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*OFF_W-1:0] start_off,
    input  logic [NUM_CH*OFF_W-1:0] step,
    input  logic [NUM_CH*OFF_W-1:0] stop_off,
    output logic [NUM_CH*OFF_W-1:0] offset,
    output logic [OFF_W-1:0]        lane_off,
    output logic                    frame_tick,
    output logic [1:0]              state,
    output logic                    done
);
    localparam int unsigned VEC_W = NUM_CH * OFF_W;
    localparam int unsigned CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(COUNTDOWN + 1);
    localparam int          LANE_NEG_I = -int'(LANE_STEP);
    localparam logic [OFF_W-1:0] LANE_POS = OFF_W'(LANE_STEP);
    localparam logic [OFF_W-1:0] LANE_NEG = OFF_W'(LANE_NEG_I);

    typedef enum logic [1:0] {
        S_COUNT = 2'd0,
        S_ANIM  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    logic [CUR_W-1:0]  cur;
    logic              vs_s1, vs_s2, vs_d;
    logic              bl_s1, bl_s2, br_s1, br_s2;

    logic [NUM_CH-1:0] hit_c;
    logic [NUM_CH-1:0] seq_fin_c;
    logic [VEC_W-1:0]  cont_nxt_c;
    logic [VEC_W-1:0]  seq_nxt_c;
    logic              has_seq_c;
    logic [CUR_W-1:0]  first_seq_c;
    logic              has_next_c;
    logic [CUR_W-1:0]  next_seq_c;

    assign state = st;

    // Per-channel next value at OFF_W+1 bits and the reach-the-bound test.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [OFF_W-1:0] off_v;
        logic signed [OFF_W-1:0] stp_v;
        logic signed [OFF_W:0]   end_v;
        logic signed [OFF_W:0]   nxt_v;

        assign off_v = offset[k*OFF_W +: OFF_W];
        assign stp_v = step[k*OFF_W +: OFF_W];
        assign end_v = $signed({stop_off[k*OFF_W+OFF_W-1], stop_off[k*OFF_W +: OFF_W]});
        assign nxt_v = $signed({off_v[OFF_W-1], off_v}) + $signed({stp_v[OFF_W-1], stp_v});

        assign hit_c[k] = (!stp_v[OFF_W-1] && (stp_v != '0) && (nxt_v >= end_v)) ||
                          ( stp_v[OFF_W-1] && (nxt_v <= end_v));
        assign seq_fin_c[k] = hit_c[k] || (stp_v == '0);
        assign cont_nxt_c[k*OFF_W +: OFF_W] = hit_c[k] ? start_off[k*OFF_W +: OFF_W]
                                                       : nxt_v[OFF_W-1:0];
        assign seq_nxt_c[k*OFF_W +: OFF_W]  = hit_c[k] ? stop_off[k*OFF_W +: OFF_W]
                                                       : nxt_v[OFF_W-1:0];
    end

    // Lowest sequential channel overall and lowest one above cur.
    always_comb begin
        has_seq_c   = 1'b0;
        first_seq_c = '0;
        has_next_c  = 1'b0;
        next_seq_c  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!mode[k]) begin
                has_seq_c   = 1'b1;
                first_seq_c = CUR_W'(k);
                if (k > int'(cur)) begin
                    has_next_c = 1'b1;
                    next_seq_c = CUR_W'(k);
                end
            end
        end
    end

    // Input synchronisers, frame-tick edge detect and lane offset.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_d       <= 1'b0;
            bl_s1      <= 1'b0;
            bl_s2      <= 1'b0;
            br_s1      <= 1'b0;
            br_s2      <= 1'b0;
            frame_tick <= 1'b0;
            lane_off   <= '0;
        end else begin
            vs_s1      <= vsync_in;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            bl_s1      <= btn_left;
            bl_s2      <= bl_s1;
            br_s1      <= btn_right;
            br_s2      <= br_s1;
            frame_tick <= restart ? 1'b0 : (vs_s2 && !vs_d);
            if (bl_s2)
                lane_off <= LANE_POS;
            else if (br_s2)
                lane_off <= LANE_NEG;
            else
                lane_off <= '0;
        end
    end

    // Sequencer: state, countdown, active channel and offsets move once per tick.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN || restart) begin
            offset <= start_off;
            st     <= S_COUNT;
            cnt    <= CNT_W'(COUNTDOWN);
            cur    <= '0;
            done   <= 1'b0;
        end else if (frame_tick) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (mode[k])
                    offset[k*OFF_W +: OFF_W] <= cont_nxt_c[k*OFF_W +: OFF_W];
                else if ((st == S_ANIM) && (int'(cur) == k))
                    offset[k*OFF_W +: OFF_W] <= seq_nxt_c[k*OFF_W +: OFF_W];
            end
            case (st)
                S_COUNT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (has_seq_c) begin
                            st  <= S_ANIM;
                            cur <= first_seq_c;
                        end else begin
                            st   <= S_HOLD;
                            done <= 1'b1;
                        end
                    end
                end
                S_ANIM: begin
                    if (seq_fin_c[cur]) begin
                        if (has_next_c) begin
                            cur <= next_seq_c;
                        end else begin
                            st   <= S_HOLD;
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    st <= S_HOLD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer against an integer reference model.
module tb_scene_sequencer;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned OFF_W     = 12;
    localparam int unsigned COUNTDOWN = 5;
    localparam int unsigned LANE_STEP = 100;
    localparam int unsigned VW        = NUM_CH * OFF_W;

    logic              CLK100MHZ = 1'b0;
    logic              CPU_RESETN, vsync_in, restart, btn_left, btn_right;
    logic [NUM_CH-1:0] mode;
    logic [VW-1:0]     start_off, step, stop_off, offset;
    logic [OFF_W-1:0]  lane_off;
    logic              frame_tick;
    logic [1:0]        state;
    logic              done;

    int vectors = 0;
    int miscompares = 0;
    int tick_seen = 0;

    int m_start[NUM_CH], m_step[NUM_CH], m_stop[NUM_CH], m_off[NUM_CH];
    int m_state, m_cnt, m_cur, m_lane;
    bit m_done;

    scene_sequencer #(.NUM_CH(NUM_CH), .OFF_W(OFF_W), .COUNTDOWN(COUNTDOWN), .LANE_STEP(LANE_STEP)) dut (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .vsync_in(vsync_in), .restart(restart),
        .btn_left(btn_left), .btn_right(btn_right), .mode(mode), .start_off(start_off),
        .step(step), .stop_off(stop_off), .offset(offset), .lane_off(lane_off),
        .frame_tick(frame_tick), .state(state), .done(done)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) if (frame_tick) tick_seen++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sx(input logic [OFF_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap(input int n);
        logic [OFF_W-1:0] t;
        t = OFF_W'(n);
        return sx(t);
    endfunction

    function automatic bit reaches(input int k, input int n);
        return (m_step[k] > 0 && n >= m_stop[k]) || (m_step[k] < 0 && n <= m_stop[k]);
    endfunction

    function automatic int next_seq(input int after);
        for (int k = after + 1; k < NUM_CH; k++)
            if (!mode[k]) return k;
        return -1;
    endfunction

    function automatic logic [VW-1:0] exp_offset();
        logic [VW-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k*OFF_W +: OFF_W] = OFF_W'(m_off[k]);
        return v;
    endfunction

    function automatic int ch(input int k);
        return sx(offset[k*OFF_W +: OFF_W]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_off[k] = m_start[k];
        m_state = 0;
        m_cnt   = COUNTDOWN;
        m_cur   = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_tick();
        int n, j;
        bit fin;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode[k]) begin
                n = m_off[k] + m_step[k];
                m_off[k] = reaches(k, n) ? m_start[k] : wrap(n);
            end
        end
        if (m_state == 1) begin
            j = m_cur;
            n = m_off[j] + m_step[j];
            fin = 1'b1;
            if (m_step[j] != 0) begin
                if (reaches(j, n)) m_off[j] = m_stop[j];
                else begin
                    m_off[j] = wrap(n);
                    fin = 1'b0;
                end
            end
            if (fin) begin
                m_cur = next_seq(j);
                if (m_cur < 0) begin
                    m_state = 2;
                    m_done = 1'b1;
                end
            end
        end else if (m_state == 0) begin
            if (m_cnt == 1) begin
                m_cur = next_seq(-1);
                if (m_cur < 0) begin
                    m_state = 2;
                    m_done = 1'b1;
                end else m_state = 1;
            end
            m_cnt--;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cfg_ch(input int k, input bit md, input int st, input int sp, input int en);
        mode[k] = md;
        start_off[k*OFF_W +: OFF_W] = OFF_W'(st);
        step[k*OFF_W +: OFF_W]      = OFF_W'(sp);
        stop_off[k*OFF_W +: OFF_W]  = OFF_W'(en);
        m_start[k] = st;
        m_step[k]  = sp;
        m_stop[k]  = en;
    endtask

    task automatic cfg_random();
        int sp;
        for (int k = 0; k < NUM_CH; k++) begin
            sp = int'($urandom_range(400, 0)) - 200;
            if ($urandom_range(3, 0) == 0) sp = 0;
            cfg_ch(k, 1'($urandom_range(1, 0)), int'($urandom_range(1000, 0)) - 500, sp,
                   int'($urandom_range(3000, 0)) - 1500);
        end
    endtask

    task automatic do_restart();
        @(negedge CLK100MHZ) restart = 1'b1;
        @(negedge CLK100MHZ) restart = 1'b0;
        model_reset();
    endtask

    task automatic pulse();
        @(negedge CLK100MHZ) vsync_in = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
        vsync_in = 1'b0;
        repeat (6) @(negedge CLK100MHZ);
        model_tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cfg_random();
        CPU_RESETN = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        model_reset();
        @(negedge CLK100MHZ);
        vectors++;
        if (offset !== exp_offset()) begin
            miscompares++;
            $display("FAIL reset_offset: got %h want %h", offset, exp_offset());
        end
        vectors++;
        if ({state, done, frame_tick, lane_off} !== {2'd0, 1'b0, 1'b0, 12'd0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: state=%0d done=%b tick=%b lane=%0d, want 0/0/0/0",
                     state, done, frame_tick, sx(lane_off));
        end
    endtask

    task automatic test_tick_timing();
        int t0;
        t0 = tick_seen;
        @(negedge CLK100MHZ) vsync_in = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK100MHZ);
            vectors++;
            if (frame_tick !== (c == 3)) begin
                miscompares++;
                $display("FAIL tick_latency cycle %0d: got %b want %b", c, frame_tick, (c == 3));
            end
        end
        repeat (995) @(negedge CLK100MHZ);
        vsync_in = 1'b0;
        repeat (6) @(negedge CLK100MHZ);
        model_tick();
        vectors++;
        if (tick_seen - t0 != 1) begin
            miscompares++;
            $display("FAIL held_vsync: got %0d ticks want 1", tick_seen - t0);
        end
        vectors++;
        if (offset !== exp_offset()) begin
            miscompares++;
            $display("FAIL held_vsync_offset: got %h want %h", offset, exp_offset());
        end
    endtask

    task automatic test_plan_sequence();
        cfg_ch(0, 1'b0, 0, -30, -600);
        cfg_ch(1, 1'b0, -170, 17, 0);
        cfg_ch(2, 1'b1, int'($urandom_range(800, 0)) - 400, 0, 1000);
        cfg_ch(3, 1'b1, int'($urandom_range(800, 0)) - 400, 0, -1000);
        do_restart();
        for (int p = 1; p <= 37; p++) begin
            pulse();
            vectors++;
            if (offset !== exp_offset() || {state, done} !== {2'(m_state), m_done}) begin
                miscompares++;
                $display("FAIL plan_seq tick %0d: off=%h st=%0d done=%b want off=%h st=%0d done=%b",
                         p, offset, state, done, exp_offset(), m_state, m_done);
            end
            if (p == 5) begin
                vectors++;
                if (state !== 2'd1 || ch(0) != 0 || ch(1) != -170) begin
                    miscompares++;
                    $display("FAIL plan_enter_anim: st=%0d ch0=%0d ch1=%0d want 1/0/-170", state, ch(0), ch(1));
                end
            end
            if (p == 25) begin
                vectors++;
                if (ch(0) != -600 || ch(1) != -170) begin
                    miscompares++;
                    $display("FAIL plan_ch0_end: ch0=%0d ch1=%0d want -600/-170", ch(0), ch(1));
                end
            end
            if (p == 34 || p == 35) begin
                vectors++;
                if (done !== (p == 35) || ch(1) != ((p == 35) ? 0 : -17)) begin
                    miscompares++;
                    $display("FAIL plan_done tick %0d: done=%b ch1=%0d", p, done, ch(1));
                end
            end
        end
    endtask

    task automatic test_clamp_and_wrap();
        cfg_ch(0, 1'b0, 0, -70, -600);
        cfg_ch(1, 1'b0, 123, 0, 500);
        cfg_ch(2, 1'b1, -200, 1, -190);
        cfg_ch(3, 1'b0, 50, 25, 100);
        do_restart();
        for (int p = 1; p <= 22; p++) begin
            pulse();
            vectors++;
            if (offset !== exp_offset() || {state, done} !== {2'(m_state), m_done}) begin
                miscompares++;
                $display("FAIL clamp_seq tick %0d: off=%h st=%0d want off=%h st=%0d",
                         p, offset, state, exp_offset(), m_state);
            end
            vectors++;
            if (ch(2) != -200 + (p % 10)) begin
                miscompares++;
                $display("FAIL wrap_ch2 tick %0d: got %0d want %0d", p, ch(2), -200 + (p % 10));
            end
            if (p == 14) begin
                vectors++;
                if (ch(0) != -600 || ch(1) != 123) begin
                    miscompares++;
                    $display("FAIL clamp_ch0: ch0=%0d ch1=%0d want -600/123", ch(0), ch(1));
                end
            end
        end
    endtask

    task automatic test_all_continuous();
        for (int k = 0; k < NUM_CH; k++)
            cfg_ch(k, 1'b1, int'($urandom_range(400, 0)) - 200, int'($urandom_range(60, 0)) - 30,
                   int'($urandom_range(1200, 0)) - 600);
        do_restart();
        for (int p = 1; p <= 7; p++) begin
            pulse();
            vectors++;
            if (offset !== exp_offset() || state !== ((p >= 5) ? 2'd2 : 2'd0) || done !== (p >= 5)) begin
                miscompares++;
                $display("FAIL all_cont tick %0d: off=%h st=%0d done=%b want off=%h", p, offset, state, done, exp_offset());
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            cfg_random();
            do_restart();
            for (int p = 1; p <= 30; p++) begin
                pulse();
                vectors++;
                if (offset !== exp_offset() || {state, done} !== {2'(m_state), m_done}) begin
                    miscompares++;
                    $display("FAIL random r%0d tick %0d: off=%h st=%0d done=%b want off=%h st=%0d done=%b",
                             r, p, offset, state, done, exp_offset(), m_state, m_done);
                end
            end
        end
    endtask

    task automatic test_lane();
        logic [1:0] pat;
        int nl;
        m_lane = 0;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: pat = 2'b10;
                1: pat = 2'b11;
                2: pat = 2'b01;
                3: pat = 2'b00;
                default: pat = 2'($urandom_range(3, 0));
            endcase
            @(negedge CLK100MHZ);
            btn_left  = pat[1];
            btn_right = pat[0];
            nl = pat[1] ? int'(LANE_STEP) : (pat[0] ? -int'(LANE_STEP) : 0);
            for (int c = 1; c <= 3; c++) begin
                @(negedge CLK100MHZ);
                vectors++;
                if (sx(lane_off) != ((c == 3) ? nl : m_lane)) begin
                    miscompares++;
                    $display("FAIL lane pat %b cycle %0d: got %0d want %0d", pat, c, sx(lane_off),
                             (c == 3) ? nl : m_lane);
                end
            end
            m_lane = nl;
        end
        @(negedge CLK100MHZ);
        btn_left = 1'b0;
        btn_right = 1'b0;
        repeat (4) @(negedge CLK100MHZ);
    endtask

    task automatic test_reset_mid_anim();
        for (int v = 0; v < 2; v++) begin
            cfg_ch(0, 1'b0, 0, -30, -600);
            cfg_ch(1, 1'b0, 0, 10, 100);
            cfg_ch(2, 1'b1, 0, 3, 1000);
            cfg_ch(3, 1'b1, 40, -3, -1000);
            btn_left = 1'b1;
            do_restart();
            repeat (15) pulse();
            vectors++;
            if (ch(0) != -300 || state !== 2'd1 || offset !== exp_offset()) begin
                miscompares++;
                $display("FAIL mid_anim_setup v%0d: ch0=%0d st=%0d want -300/1", v, ch(0), state);
            end
            @(negedge CLK100MHZ) vsync_in = 1'b1;
            repeat (2) @(negedge CLK100MHZ);
            vsync_in = 1'b0;
            @(negedge CLK100MHZ);
            vectors++;
            if (frame_tick !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_anim_tick v%0d: got %b want 1", v, frame_tick);
            end
            if (v == 0) CPU_RESETN = 1'b0;
            else restart = 1'b1;
            @(negedge CLK100MHZ);
            model_reset();
            vectors++;
            if (offset !== exp_offset() || state !== 2'd0 || done !== 1'b0 ||
                sx(lane_off) != ((v == 0) ? 0 : int'(LANE_STEP))) begin
                miscompares++;
                $display("FAIL mid_anim_%s: off=%h st=%0d lane=%0d want off=%h st=0 lane=%0d",
                         (v == 0) ? "reset" : "restart", offset, state, sx(lane_off), exp_offset(),
                         (v == 0) ? 0 : int'(LANE_STEP));
            end
            CPU_RESETN = 1'b1;
            restart = 1'b0;
            repeat (4) @(negedge CLK100MHZ);
            vectors++;
            if (sx(lane_off) != int'(LANE_STEP) || frame_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_anim_recover v%0d: lane=%0d tick=%b", v, sx(lane_off), frame_tick);
            end
            pulse();
            vectors++;
            if (offset !== exp_offset() || state !== 2'(m_state)) begin
                miscompares++;
                $display("FAIL mid_anim_after v%0d: off=%h want %h", v, offset, exp_offset());
            end
        end
        btn_left = 1'b0;
        repeat (4) @(negedge CLK100MHZ);
    endtask

    initial begin
        CPU_RESETN = 1'b0;
        vsync_in   = 1'b0;
        restart    = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        mode       = '0;
        start_off  = '0;
        step       = '0;
        stop_off   = '0;
        test_reset();
        test_tick_timing();
        test_plan_sequence();
        test_clamp_and_wrap();
        test_all_continuous();
        test_random();
        test_lane();
        test_reset_mid_anim();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
